// File: rtl/ni_local_port.sv
// Core-side network interface for the router's local port: an injection FIFO feeding a
// send/wait/check retry FSM, and a dual-write ejection FIFO drained through valid/ready.
module ni_local_port #(
  parameter int unsigned INJ_DEPTH = 4,
  parameter int unsigned EJ_DEPTH  = 8,
  parameter int unsigned RETRY_W   = 8,
  parameter int unsigned FLIT_W    = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              core_inj_vld,
  output logic              core_inj_rdy,
  input  logic [FLIT_W-1:0] core_inj_flit,
  output logic              core_ej_vld,
  input  logic              core_ej_rdy,
  output logic [FLIT_W-1:0] core_ej_flit,
  output logic [FLIT_W-1:0] rtr_din_l,
  input  logic              rtr_inj_gnt,
  input  logic [FLIT_W-1:0] rtr_dout_l_1,
  input  logic [FLIT_W-1:0] rtr_dout_l_2,
  output logic              ej_overflow,
  output logic [RETRY_W-1:0] inj_retry_cnt
);

  // Flit valid flag lives in the MSB of the extended flit.
  localparam int unsigned VldBit = FLIT_W - 1;
  localparam int unsigned InjAw  = $clog2(INJ_DEPTH);
  localparam int unsigned InjCw  = InjAw + 1;
  localparam int unsigned EjAw   = $clog2(EJ_DEPTH);
  localparam int unsigned EjCw   = EjAw + 1;
  localparam logic [InjCw-1:0] InjDepthC = InjCw'(INJ_DEPTH);
  localparam logic [EjCw-1:0]  EjDepthC  = EjCw'(EJ_DEPTH);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StCheck} inj_state_e;

  // ---------------------------------------------------------------------------
  // Injection FIFO
  // ---------------------------------------------------------------------------
  logic [FLIT_W-1:0] inj_mem [INJ_DEPTH];
  logic [InjAw-1:0]  inj_wr_q, inj_wr_d, inj_rd_q, inj_rd_d;
  logic [InjCw-1:0]  inj_cnt_q, inj_cnt_d;
  logic              inj_push, inj_pop;
  logic [FLIT_W-1:0] inj_head;

  inj_state_e         state_q, state_d;
  logic [FLIT_W-1:0]  din_q, din_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  // Held low throughout reset, not just while the FIFO is full.
  assign core_inj_rdy = n_rst && (inj_cnt_q != InjDepthC);
  assign inj_push     = core_inj_vld && core_inj_rdy;
  assign inj_pop      = (state_q == StCheck) && rtr_inj_gnt;
  assign inj_head     = inj_mem[inj_rd_q];

  always_comb begin
    inj_wr_d  = inj_wr_q;
    inj_rd_d  = inj_rd_q;
    inj_cnt_d = inj_cnt_q + InjCw'(inj_push) - InjCw'(inj_pop);
    if (inj_push) inj_wr_d = inj_wr_q + InjAw'(1);
    if (inj_pop)  inj_rd_d = inj_rd_q + InjAw'(1);
  end

  always_ff @(posedge clk) begin
    if (inj_push) inj_mem[inj_wr_q] <= core_inj_flit;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      inj_wr_q  <= '0;
      inj_rd_q  <= '0;
      inj_cnt_q <= '0;
    end else begin
      inj_wr_q  <= inj_wr_d;
      inj_rd_q  <= inj_rd_d;
      inj_cnt_q <= inj_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Injection FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      din_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (inj_cnt_q != '0) state_d = StSend;
      StSend:  state_d = StWait;
      StWait:  state_d = StCheck;
      StCheck: state_d = rtr_inj_gnt ? StIdle : StSend;
      default: state_d = StIdle;
    endcase
  end

  // The head cannot change between entering SEND and its grant, so it is safe
  // to register it on the transition into SEND.
  always_comb begin
    din_d   = '0;
    retry_d = retry_q;
    if (state_d == StSend) begin
      din_d         = inj_head;
      din_d[VldBit] = 1'b1;
    end
    if (state_q == StCheck) begin
      if (rtr_inj_gnt)      retry_d = '0;
      else if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
    end
  end

  assign rtr_din_l     = din_q;
  assign inj_retry_cnt = retry_q;

  // ---------------------------------------------------------------------------
  // Ejection FIFO: up to two writes per cycle, one read
  // ---------------------------------------------------------------------------
  logic [FLIT_W-1:0] ej_mem [EJ_DEPTH];
  logic [EjAw-1:0]   ej_wr_q, ej_wr_d, ej_rd_q, ej_rd_d, ej_wr2_addr;
  logic [EjCw-1:0]   ej_cnt_q, ej_cnt_d, ej_space;
  logic              ej_w1, ej_w2, ej_drop, ej_pop;
  logic              ovf_q, ovf_d;

  // Space excludes this cycle's pop: the router cannot be stalled, so a write
  // is only accepted into a slot that is already free.
  assign ej_space    = EjDepthC - ej_cnt_q;
  assign ej_w1       = rtr_dout_l_1[VldBit] && (ej_space != '0);
  assign ej_w2       = rtr_dout_l_2[VldBit] && (ej_space > EjCw'(ej_w1));
  assign ej_drop     = (rtr_dout_l_1[VldBit] && !ej_w1) || (rtr_dout_l_2[VldBit] && !ej_w2);
  assign ej_wr2_addr = ej_w1 ? ej_wr_q + EjAw'(1) : ej_wr_q;
  assign ej_pop      = core_ej_vld && core_ej_rdy;

  always_comb begin
    ej_rd_d  = ej_rd_q;
    ej_wr_d  = ej_wr_q + EjAw'(ej_w1) + EjAw'(ej_w2);
    ej_cnt_d = ej_cnt_q + EjCw'(ej_w1) + EjCw'(ej_w2) - EjCw'(ej_pop);
    ovf_d    = ovf_q || ej_drop;
    if (ej_pop) ej_rd_d = ej_rd_q + EjAw'(1);
  end

  always_ff @(posedge clk) begin
    if (ej_w1) ej_mem[ej_wr_q]     <= rtr_dout_l_1;
    if (ej_w2) ej_mem[ej_wr2_addr] <= rtr_dout_l_2;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ej_wr_q  <= '0;
      ej_rd_q  <= '0;
      ej_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ej_wr_q  <= ej_wr_d;
      ej_rd_q  <= ej_rd_d;
      ej_cnt_q <= ej_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign core_ej_vld  = (ej_cnt_q != '0);
  assign core_ej_flit = ej_mem[ej_rd_q];
  assign ej_overflow  = ovf_q;

endmodule

// File: tb/tb_ni_local_port.sv
// Directed self-checking bench for ni_local_port: injection retry FSM, ejection FIFO
// overflow/ordering and mid-operation reset.
module tb_ni_local_port;

  localparam logic [31:0] Vld = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        core_inj_vld = 1'b0;
  logic        core_inj_rdy;
  logic [31:0] core_inj_flit = '0;
  logic        core_ej_vld;
  logic        core_ej_rdy = 1'b0;
  logic [31:0] core_ej_flit;
  logic [31:0] rtr_din_l;
  logic        rtr_inj_gnt = 1'b0;
  logic [31:0] rtr_dout_l_1 = '0;
  logic [31:0] rtr_dout_l_2 = '0;
  logic        ej_overflow;
  logic [7:0]  inj_retry_cnt;

  int checks = 0;
  int fails  = 0;

  ni_local_port dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .core_inj_vld (core_inj_vld),
    .core_inj_rdy (core_inj_rdy),
    .core_inj_flit(core_inj_flit),
    .core_ej_vld  (core_ej_vld),
    .core_ej_rdy  (core_ej_rdy),
    .core_ej_flit (core_ej_flit),
    .rtr_din_l    (rtr_din_l),
    .rtr_inj_gnt  (rtr_inj_gnt),
    .rtr_dout_l_1 (rtr_dout_l_1),
    .rtr_dout_l_2 (rtr_dout_l_2),
    .ej_overflow  (ej_overflow),
    .inj_retry_cnt(inj_retry_cnt)
  );

  always #5 clk = ~clk;

  // Each slot starts 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] f);
    core_inj_vld  = 1'b1;
    core_inj_flit = f;
    step();
    core_inj_vld  = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    step();
    checks++;
    if (rtr_din_l !== 32'h0 || core_ej_vld !== 1'b0 || core_inj_rdy !== 1'b0 ||
        ej_overflow !== 1'b0 || inj_retry_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_state: din=%h ej_vld=%b inj_rdy=%b ovf=%b retry=%0d expected 0,0,0,0,0",
               rtr_din_l, core_ej_vld, core_inj_rdy, ej_overflow, inj_retry_cnt);
    end
    n_rst = 1'b1;
    #1;
    checks++;
    if (core_inj_rdy !== 1'b1) begin
      fails++;
      $display("FAIL inj_rdy_after_reset: got %b expected 1", core_inj_rdy);
    end
  endtask

  task automatic test_single_grant();
    logic [31:0] a = {1'b0, 3'd2, 3'd1, 25'h0AA};
    int vld_cycles = 0;
    push(a);
    step();
    checks++;
    if (rtr_din_l !== (a | Vld)) begin
      fails++;
      $display("FAIL single_send: din=%h expected %h", rtr_din_l, a | Vld);
    end
    step();
    checks++;
    if (rtr_din_l !== 32'h0) begin
      fails++;
      $display("FAIL single_wait_zero: din=%h expected 0", rtr_din_l);
    end
    step();
    rtr_inj_gnt = 1'b1;
    step();
    rtr_inj_gnt = 1'b0;
    checks++;
    if (inj_retry_cnt !== 8'd0) begin
      fails++;
      $display("FAIL single_retry: got %0d expected 0", inj_retry_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      if (rtr_din_l[31] === 1'b1) vld_cycles++;
      step();
    end
    checks++;
    if (vld_cycles !== 0) begin
      fails++;
      $display("FAIL single_popped: resends=%0d expected 0", vld_cycles);
    end
  endtask

  task automatic test_retry();
    logic [31:0] a = {1'b1, 3'd2, 3'd1, 25'h155};
    int n = 0;
    push(a);
    while (rtr_din_l[31] !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rtr_din_l !== a) begin
        fails++;
        $display("FAIL retry_send%0d: din=%h expected %h", i, rtr_din_l, a);
      end
      step();
      step();
      rtr_inj_gnt = (i == 3);
      step();
      rtr_inj_gnt = 1'b0;
      checks++;
      if (inj_retry_cnt !== ((i < 3) ? 8'(i + 1) : 8'd0)) begin
        fails++;
        $display("FAIL retry_cnt%0d: got %0d expected %0d", i, inj_retry_cnt,
                 (i < 3) ? i + 1 : 0);
      end
    end
    checks++;
    if (rtr_din_l !== 32'h0) begin
      fails++;
      $display("FAIL retry_idle: din=%h expected 0", rtr_din_l);
    end
  endtask

  task automatic test_gnt_outside_check();
    logic [31:0] b = {1'b0, 3'd5, 3'd3, 25'h1234};
    push(b);
    rtr_inj_gnt = 1'b1;   // IDLE
    step();
    checks++;
    if (rtr_din_l !== (b | Vld)) begin
      fails++;
      $display("FAIL stray_send: din=%h expected %h", rtr_din_l, b | Vld);
    end
    step();               // WAIT, grant still high
    rtr_inj_gnt = 1'b0;
    step();               // CHECK, no grant
    step();
    checks++;
    if (rtr_din_l !== (b | Vld) || inj_retry_cnt !== 8'd1) begin
      fails++;
      $display("FAIL stray_no_pop: din=%h retry=%0d expected %h,1",
               rtr_din_l, inj_retry_cnt, b | Vld);
    end
    step();
    step();
    rtr_inj_gnt = 1'b1;
    step();
    rtr_inj_gnt = 1'b0;
    checks++;
    if (inj_retry_cnt !== 8'd0) begin
      fails++;
      $display("FAIL stray_final_retry: got %0d expected 0", inj_retry_cnt);
    end
  endtask

  task automatic test_ej_overflow();
    logic [31:0] exp [8];
    for (int i = 0; i < 7; i++) exp[i] = Vld | 32'(16'hE000 + i);
    exp[7] = Vld | 32'h0000_0A11;
    core_ej_rdy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rtr_dout_l_1 = exp[i];
      step();
      if (i == 0) begin
        checks++;
        if (core_ej_vld !== 1'b1) begin
          fails++;
          $display("FAIL ej_latency: ej_vld=%b expected 1", core_ej_vld);
        end
      end
    end
    checks++;
    if (ej_overflow !== 1'b0 || core_ej_flit !== exp[0]) begin
      fails++;
      $display("FAIL ej_fill7: ovf=%b head=%h expected 0,%h", ej_overflow, core_ej_flit, exp[0]);
    end
    rtr_dout_l_1 = exp[7];
    rtr_dout_l_2 = Vld | 32'h0000_0B22;
    step();
    rtr_dout_l_1 = '0;
    rtr_dout_l_2 = '0;
    checks++;
    if (ej_overflow !== 1'b1) begin
      fails++;
      $display("FAIL ej_overflow_set: got %b expected 1", ej_overflow);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (core_ej_vld !== 1'b1 || core_ej_flit !== exp[i]) begin
        fails++;
        $display("FAIL ej_drain%0d: vld=%b flit=%h expected 1,%h",
                 i, core_ej_vld, core_ej_flit, exp[i]);
      end
      core_ej_rdy = 1'b1;
      step();
      core_ej_rdy = 1'b0;
    end
    checks++;
    if (core_ej_vld !== 1'b0 || ej_overflow !== 1'b1) begin
      fails++;
      $display("FAIL ej_empty_sticky: vld=%b ovf=%b expected 0,1", core_ej_vld, ej_overflow);
    end
  endtask

  task automatic test_ej_dual_order();
    logic [31:0] exp [5];
    for (int i = 0; i < 3; i++) exp[i] = Vld | 32'(16'hF000 + i);
    exp[3] = Vld | 32'h0000_0111;
    exp[4] = Vld | 32'h0000_0222;
    for (int i = 0; i < 3; i++) begin
      rtr_dout_l_1 = exp[i];
      step();
    end
    rtr_dout_l_1 = exp[3];
    rtr_dout_l_2 = exp[4];
    core_ej_rdy  = 1'b1;
    checks++;
    if (core_ej_flit !== exp[0]) begin
      fails++;
      $display("FAIL dual_head: flit=%h expected %h", core_ej_flit, exp[0]);
    end
    step();
    rtr_dout_l_1 = '0;
    rtr_dout_l_2 = '0;
    core_ej_rdy  = 1'b0;
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (core_ej_vld !== 1'b1 || core_ej_flit !== exp[i]) begin
        fails++;
        $display("FAIL dual_order%0d: vld=%b flit=%h expected 1,%h",
                 i, core_ej_vld, core_ej_flit, exp[i]);
      end
      core_ej_rdy = 1'b1;
      step();
      core_ej_rdy = 1'b0;
    end
    checks++;
    if (core_ej_vld !== 1'b0) begin
      fails++;
      $display("FAIL dual_count4: vld=%b expected 0 after 4 pops", core_ej_vld);
    end
  endtask

  task automatic test_reset_mid_flight();
    logic [31:0] c = {1'b0, 3'd1, 3'd1, 25'h0C0C};
    logic [31:0] d = {1'b0, 3'd1, 3'd2, 25'h0D0D};
    int resends = 0;
    rtr_dout_l_1 = Vld | 32'h0000_0E0E;
    step();
    rtr_dout_l_1 = '0;
    core_inj_vld  = 1'b1;
    core_inj_flit = c;
    step();
    core_inj_flit = d;
    step();
    core_inj_vld  = 1'b0;
    checks++;
    if (rtr_din_l !== (c | Vld)) begin
      fails++;
      $display("FAIL rst_pre_send: din=%h expected %h", rtr_din_l, c | Vld);
    end
    step();               // WAIT
    n_rst = 1'b0;
    #1;
    checks++;
    if (rtr_din_l !== 32'h0 || core_ej_vld !== 1'b0 || core_inj_rdy !== 1'b0 ||
        ej_overflow !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: din=%h ej_vld=%b inj_rdy=%b ovf=%b expected 0,0,0,0",
               rtr_din_l, core_ej_vld, core_inj_rdy, ej_overflow);
    end
    step();
    n_rst = 1'b1;
    rtr_inj_gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rtr_din_l !== 32'h0) resends++;
    end
    rtr_inj_gnt = 1'b0;
    checks++;
    if (resends !== 0 || core_ej_vld !== 1'b0 || inj_retry_cnt !== 8'd0) begin
      fails++;
      $display("FAIL rst_after: resends=%0d ej_vld=%b retry=%0d expected 0,0,0",
               resends, core_ej_vld, inj_retry_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_retry();
    test_gnt_outside_check();
    test_ej_overflow();
    test_ej_dual_order();
    test_reset_mid_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
